intc_controller: RTL and testbench

Interrupt controller sitting directly downstream of the timer generator and upstream of the RV32IC core's trap logic. Latches the one-cycle timer flag, an optional NMI pulse and `N_EXT` level-sensitive external lines, arbitrates them by fixed priority and presents one request at a time to the core over a req/ack handshake. Holds the in-service state until the core signals handler return (`mret`).

---
 rtl/intc_pkg.sv | 21 ++
 rtl/intc_sync.sv | 39 +++
 rtl/intc_controller.sv | 160 ++++++++++++++++
 tb/tb_intc_controller.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/intc_pkg.sv
// -----------------------------------------------------------------------------
// intc_pkg
// Shared definitions for the interrupt controller:
//   - cause code width and the fixed cause constants (NMI, timer, ext base)
//   - FSM state type used by intc_controller
// -----------------------------------------------------------------------------
package intc_pkg;

    localparam int CAUSE_W = 5;

    localparam logic [CAUSE_W-1:0] CAUSE_NMI      = 5'd0;
    localparam logic [CAUSE_W-1:0] CAUSE_TMR      = 5'd1;
    localparam logic [CAUSE_W-1:0] CAUSE_EXT_BASE = 5'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } intc_state_t;

endpackage : intc_pkg

// File: rtl/intc_sync.sv
// -----------------------------------------------------------------------------
// intc_sync
// Parameterized-width two-flop synchronizer for asynchronous level inputs.
// Ports:
//   clk    in  1  destination clock
//   rst_n  in  1  asynchronous active-low reset (both stages clear to 0)
//   d      in  W  asynchronous input
//   q      out W  synchronized output, two clk edges after d settles
// -----------------------------------------------------------------------------
module intc_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_reg;
    logic [W-1:0] sync_reg;

    // Each bit is an independent synchronizer chain.
    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_bit
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    meta_reg[gi] <= 1'b0;
                    sync_reg[gi] <= 1'b0;
                end else begin
                    meta_reg[gi] <= d[gi];
                    sync_reg[gi] <= meta_reg[gi];
                end
            end
        end
    endgenerate

    assign q = sync_reg;

endmodule : intc_sync

// File: rtl/intc_controller.sv
// -----------------------------------------------------------------------------
// intc_controller
// Fixed-priority interrupt controller between the timer generator and the
// core trap logic. Latches timer/NMI pulses, synchronizes external level
// lines, and presents one request at a time over an irq_req/irq_ack handshake,
// holding in-service until irq_done (mret).
//
// Optional feature macro: INTC_NMI_EN
//   defined   -> nmi pulses latch into pend_nmi and issue cause 0
//   undefined -> nmi ignored, pend_nmi reads 0, cause 0 never issued
//
// Ports:
//   clk          in  1        core clock
//   rst_n        in  1        asynchronous active-low reset
//   tmrF         in  1        one-cycle timer pulse
//   nmi          in  1        one-cycle NMI pulse
//   ext_irq      in  N_EXT    asynchronous level-sensitive external lines
//   gie          in  1        global interrupt enable
//   tmr_en       in  1        timer interrupt enable
//   ext_mask     in  N_EXT    per-line enable (1 = enabled)
//   irq_ack      in  1        core accepts current request
//   irq_done     in  1        handler return pulse
//   irq_req      out 1        request to core
//   irq_cause    out 5        cause of current request
//   irq_pending  out N_EXT+2  raw pending {ext, tmr, nmi}
// -----------------------------------------------------------------------------
module intc_controller
    import intc_pkg::*;
#(
    parameter int N_EXT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tmrF,
    input  logic               nmi,
    input  logic [N_EXT-1:0]   ext_irq,
    input  logic               gie,
    input  logic               tmr_en,
    input  logic [N_EXT-1:0]   ext_mask,
    input  logic               irq_ack,
    input  logic               irq_done,
    output logic               irq_req,
    output logic [CAUSE_W-1:0] irq_cause,
    output logic [N_EXT+1:0]   irq_pending
);

    localparam int NSRC = N_EXT + 2;

    logic [N_EXT-1:0]   ext_sync;
    logic               pend_nmi_reg;
    logic               pend_tmr_reg;
    logic               pend_tmr_next;
    intc_state_t        state_reg;
    intc_state_t        state_next;
    logic [CAUSE_W-1:0] cause_reg;
    logic [CAUSE_W-1:0] cause_next;
    logic [NSRC-1:0]    elig;
    logic               any_elig;
    logic [CAUSE_W-1:0] top_cause;
    logic               cur_elig;
    logic               ack_take;

    intc_sync #(.W(N_EXT)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ext_irq),
        .q     (ext_sync)
    );

    // Eligibility vector, indexed by cause code.
    assign elig[0] = pend_nmi_reg;
    assign elig[1] = gie & tmr_en & pend_tmr_reg;
    generate
        for (genvar gi = 0; gi < N_EXT; gi++) begin : g_elig
            assign elig[2+gi] = gie & ext_mask[gi] & ext_sync[gi];
        end
    endgenerate

    // Lowest cause number wins: scan from the bottom priority upward so the
    // last hit is the highest priority.
    always_comb begin
        any_elig  = |elig;
        top_cause = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (elig[i]) top_cause = CAUSE_W'(i);
        end
    end

    // Whether the cause currently frozen in REQ is still eligible.
    always_comb begin
        cur_elig = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (cause_reg == CAUSE_W'(i)) cur_elig = elig[i];
        end
    end

    always_comb begin
        state_next = state_reg;
        cause_next = cause_reg;
        ack_take   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (any_elig) begin
                    state_next = REQ;
                    cause_next = top_cause;
                end
            end
            REQ: begin
                // Ack takes precedence over a simultaneous loss of eligibility.
                if (irq_ack) begin
                    state_next = SERVICE;
                    ack_take   = 1'b1;
                end else if (cause_reg != CAUSE_NMI && !cur_elig) begin
                    state_next = IDLE;
                end
            end
            SERVICE: begin
                if (irq_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cause_reg <= '0;
        end else begin
            state_reg <= state_next;
            cause_reg <= cause_next;
        end
    end

    // A new pulse on the same edge as the clearing ack keeps the bit set.
    assign pend_tmr_next = tmrF | (pend_tmr_reg & ~(ack_take & (cause_reg == CAUSE_TMR)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend_tmr_reg <= 1'b0;
        else        pend_tmr_reg <= pend_tmr_next;
    end

`ifdef INTC_NMI_EN
    logic pend_nmi_next;
    assign pend_nmi_next = nmi | (pend_nmi_reg & ~(ack_take & (cause_reg == CAUSE_NMI)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend_nmi_reg <= 1'b0;
        else        pend_nmi_reg <= pend_nmi_next;
    end
`else
    logic unused_nmi;
    assign unused_nmi   = nmi;
    assign pend_nmi_reg = 1'b0;
`endif

    assign irq_req     = (state_reg == REQ);
    assign irq_cause   = cause_reg;
    assign irq_pending = {ext_sync, pend_tmr_reg, pend_nmi_reg};

endmodule : intc_controller

// File: tb/tb_intc_controller.sv
// -----------------------------------------------------------------------------
// tb_intc_controller
// Directed self-checking bench for intc_controller (N_EXT = 4). Expected
// values are queued per step and compared against the outputs after the step.
// -----------------------------------------------------------------------------
module tb_intc_controller;

    localparam int N_EXT = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             tmrF;
    logic             nmi;
    logic [N_EXT-1:0] ext_irq;
    logic             gie;
    logic             tmr_en;
    logic [N_EXT-1:0] ext_mask;
    logic             irq_ack;
    logic             irq_done;
    logic             irq_req;
    logic [4:0]       irq_cause;
    logic [N_EXT+1:0] irq_pending;

    intc_controller #(.N_EXT(N_EXT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tmrF        (tmrF),
        .nmi         (nmi),
        .ext_irq     (ext_irq),
        .gie         (gie),
        .tmr_en      (tmr_en),
        .ext_mask    (ext_mask),
        .irq_ack     (irq_ack),
        .irq_done    (irq_done),
        .irq_req     (irq_req),
        .irq_cause   (irq_cause),
        .irq_pending (irq_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          sel;   // 0 = irq_req, 1 = irq_cause, 2 = irq_pending
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic e_req(input string tag, input logic v);
        sb_q.push_back('{tag, 0, 32'(v)});
    endtask

    task automatic e_cause(input string tag, input logic [4:0] v);
        sb_q.push_back('{tag, 1, 32'(v)});
    endtask

    task automatic e_pend(input string tag, input logic [N_EXT+1:0] v);
        sb_q.push_back('{tag, 2, 32'(v)});
    endtask

    // Pop every queued expectation and compare against the current outputs.
    task automatic chk();
        exp_t        e;
        logic [31:0] obs;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.sel)
                0:       obs = 32'(irq_req);
                1:       obs = 32'(irq_cause);
                default: obs = 32'(irq_pending);
            endcase
            total++;
            assert (obs === e.exp) begin
                $display("check %s: value=%0h ok", e.tag, obs);
            end else begin
                bad++;
                $error("FAIL %s: observed=%0h expected=%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; tmrF = 1'b0; nmi = 1'b0; ext_irq = '0;
        gie = 1'b0; tmr_en = 1'b0; ext_mask = '0; irq_ack = 1'b0; irq_done = 1'b0;

        // Reset state
        tick(); tick();
        e_req("rst_req", 1'b0); e_cause("rst_cause", 5'd0); e_pend("rst_pend", 6'b0); chk();
        rst_n = 1'b1;
        gie = 1'b1; tmr_en = 1'b1;
        tick();

        // 1: timer pulse -> request cause 1 after E1, ack clears pending
        tmrF = 1'b1; tick(); tmrF = 1'b0;
        e_req("t1_e0_req", 1'b0); e_pend("t1_e0_pend", 6'b000010); chk();
        tick();
        e_req("t1_e1_req", 1'b1); e_cause("t1_e1_cause", 5'd1); chk();
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        e_req("t1_ack_req", 1'b0); e_pend("t1_ack_pend", 6'b0); chk();
        irq_done = 1'b1; tick(); irq_done = 1'b0;
        tick();
        e_req("t1_idle_req", 1'b0); chk();

        // 2: timer + ext[0] together -> cause 1 first, then cause 2
        ext_mask = 4'b0001; ext_irq = 4'b0001; tmrF = 1'b1;
        tick(); tmrF = 1'b0;
        tick();
        e_req("t2_req1", 1'b1); e_cause("t2_cause1", 5'd1); e_pend("t2_pend1", 6'b000110); chk();
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        e_req("t2_svc1_req", 1'b0); e_pend("t2_svc1_pend", 6'b000100); chk();
        irq_done = 1'b1; tick(); irq_done = 1'b0;
        e_req("t2_idle_req", 1'b0); chk();
        tick();
        e_req("t2_req2", 1'b1); e_cause("t2_cause2", 5'd2); chk();
        irq_ack = 1'b1; ext_irq = 4'b0000; tick(); irq_ack = 1'b0;
        e_req("t2_svc2_req", 1'b0); e_pend("t2_svc2_pend", 6'b000100); chk();
        irq_done = 1'b1; tick(); irq_done = 1'b0;
        e_pend("t2_done_pend", 6'b0); chk();
        tick();
        e_req("t2_quiet_req", 1'b0); chk();
        ext_mask = 4'b0000;

        // 3: gie=0 holds timer pending without request; raising gie requests
        gie = 1'b0;
        tmrF = 1'b1; tick(); tmrF = 1'b0;
        tick();
        e_req("t3_masked_req", 1'b0); e_pend("t3_masked_pend", 6'b000010); chk();
        gie = 1'b1; tick();
        e_req("t3_gie_req", 1'b1); e_cause("t3_gie_cause", 5'd1); chk();
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        irq_done = 1'b1; tick(); irq_done = 1'b0;
        e_req("t3_end_req", 1'b0); e_pend("t3_end_pend", 6'b0); chk();

        // 4: cause 3 in REQ, mask drop -> back to IDLE, pending preserved
        ext_mask = 4'b0010; ext_irq = 4'b0010;
        tick(); tick();
        e_req("t4_e1_req", 1'b0); chk();
        tick();
        e_req("t4_req", 1'b1); e_cause("t4_cause", 5'd3); chk();
        ext_mask = 4'b0000; tick();
        e_req("t4_drop_req", 1'b0); e_pend("t4_drop_pend", 6'b001000); chk();
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;   // ack outside REQ ignored
        e_req("t4_stray_ack_req", 1'b0); chk();
        ext_irq = 4'b0000; tick(); tick();
        e_pend("t4_clear_pend", 6'b0); chk();

        // 5: timer pulse on the ack edge keeps pending and reissues
        tmrF = 1'b1; tick(); tmrF = 1'b0; tick();
        e_req("t5_req", 1'b1); e_cause("t5_cause", 5'd1); chk();
        irq_ack = 1'b1; tmrF = 1'b1; tick(); irq_ack = 1'b0; tmrF = 1'b0;
        e_req("t5_ack_req", 1'b0); e_pend("t5_ack_pend", 6'b000010); chk();
        tick();
        e_req("t5_svc_req", 1'b0); chk();
        irq_done = 1'b1; tick(); irq_done = 1'b0;
        e_req("t5_done_req", 1'b0); chk();
        tick();
        e_req("t5_reissue_req", 1'b1); e_cause("t5_reissue_cause", 5'd1); chk();
        irq_done = 1'b1; tick(); irq_done = 1'b0;   // done outside SERVICE ignored
        e_req("t5_stray_done_req", 1'b1); chk();
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        irq_done = 1'b1; tick(); irq_done = 1'b0;
        e_pend("t5_end_pend", 6'b0); chk();

        // 6: NMI with gie=0
        gie = 1'b0;
        nmi = 1'b1; tick(); nmi = 1'b0;
`ifdef INTC_NMI_EN
        e_req("t6_e0_req", 1'b0); e_pend("t6_e0_pend", 6'b000001); chk();
        tick();
        e_req("t6_req", 1'b1); e_cause("t6_cause", 5'd0); chk();
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        e_req("t6_ack_req", 1'b0); e_pend("t6_ack_pend", 6'b0); chk();
        irq_done = 1'b1; tick(); irq_done = 1'b0;
`else
        e_req("t6_e0_req", 1'b0); e_pend("t6_e0_pend", 6'b0); chk();
        tick();
        e_req("t6_noreq", 1'b0); chk();
`endif
        gie = 1'b1;

        // 7: reset mid-request drops request and latched pulses at once
        tmrF = 1'b1; tick(); tmrF = 1'b0; tick();
        e_req("t7_req", 1'b1); chk();
        tmrF = 1'b1; tick(); tmrF = 1'b0;   // timer pending again while in REQ
        rst_n = 1'b0; #1;
        e_req("t7_rst_req", 1'b0); e_cause("t7_rst_cause", 5'd0); e_pend("t7_rst_pend", 6'b0); chk();
        rst_n = 1'b1;
        tick(); tick();
        e_req("t7_after_req", 1'b0); chk();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_intc_controller
